// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared op codes, state encoding and lane helper for the memory sequencer
package mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_LW   = 2'b00,
        OP_SW   = 2'b01,
        OP_SB   = 2'b10,
        OP_XCHG = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_RD_B   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_WR_A   = 3'd5,
        ST_WR_B   = 3'd6,
        ST_RESP   = 3'd7
    } seq_state_e;

    // One-hot byte-lane select, lane 0 = bits [7:0]
    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// rtl/mem_byte_merge.sv - replace one little-endian byte lane of a 32-bit word
module mem_byte_merge
    import mem_seq_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);

    logic [3:0] sel;

    always_comb begin
        sel      = lane_sel(lane_i);
        merged_o = word_i;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged_o[8*i +: 8] = byte_i;
            end
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - sequences LW/SW/SB/XCHG ops onto a single shared memory port
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_access_sequencer: MEM_LAT must be >= 1");
    end
    if (DATA_W != 32) begin : g_bad_width
        $error("mem_access_sequencer: DATA_W must be 32");
    end

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    seq_state_e        state_q;
    mem_op_e           op_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [7:0]        sb_byte_q;
    logic [DATA_W-1:0] word_a_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] sb_merged_d;

    // Merge works on the word arriving this cycle so the SB write can issue right after WAIT_A
    mem_byte_merge u_merge (
        .word_i   (mem_rdata),
        .byte_i   (sb_byte_q),
        .lane_i   (addr_a_q[1:0]),
        .merged_o (sb_merged_d)
    );

    // Outputs are registered: each transition loads the strobes for the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            sb_byte_q   <= '0;
            word_a_q    <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= mem_op_e'(req_op);
                        addr_a_q   <= req_addr_a;
                        addr_b_q   <= align(req_addr_b);
                        sb_byte_q  <= req_wdata[7:0];
                        mem_addr_q <= align(req_addr_a);
                        if (req_op == OP_SW) begin
                            state_q     <= ST_WR_A;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= ST_RD_A;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ST_RD_A: begin
                    state_q <= ST_WAIT_A;
                    cnt_q   <= CNT_LAST;
                end
                ST_WAIT_A: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        word_a_q <= mem_rdata;
                        case (op_q)
                            OP_LW: begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= mem_rdata;
                            end
                            OP_SB: begin
                                state_q     <= ST_WR_A;
                                mem_write_q <= 1'b1;
                                mem_addr_q  <= align(addr_a_q);
                                mem_wdata_q <= sb_merged_d;
                            end
                            default: begin
                                state_q    <= ST_RD_B;
                                mem_read_q <= 1'b1;
                                mem_addr_q <= addr_b_q;
                            end
                        endcase
                    end
                end
                ST_RD_B: begin
                    state_q <= ST_WAIT_B;
                    cnt_q   <= CNT_LAST;
                end
                ST_WAIT_B: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q     <= ST_WR_A;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= align(addr_a_q);
                        mem_wdata_q <= mem_rdata;
                    end
                end
                ST_WR_A: begin
                    if (op_q == OP_XCHG) begin
                        state_q     <= ST_WR_B;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= addr_b_q;
                        mem_wdata_q <= word_a_q;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_WR_B: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= word_a_q;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
